// File: rtl/cache_flush_walker.sv
`default_nettype none
// ============================================================================
// Module   : cache_flush_walker
// Purpose  : Walks every (line, way) of one bank through the tag stage's flush
//            port and turns dirty evictions into {tag,line} writeback requests.
// Revision : 1.0
// ============================================================================
module cache_flush_walker #(
    parameter  int CACHE_SIZE     = 1024,
    parameter  int LINE_SIZE      = 16,
    parameter  int NUM_BANKS      = 1,
    parameter  int NUM_WAYS       = 1,
    parameter  int TAG_BITS       = 20,
    localparam int LINES_PER_BANK = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
    localparam int LSB            = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1,
    localparam int WCW            = LSB + $clog2(NUM_WAYS) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    input  logic                    req_inval_only,
    output logic                    req_ready,
    output logic                    busy,
    output logic                    probe_valid,
    input  logic                    probe_ready,
    output logic [LSB-1:0]          probe_line,
    output logic [NUM_WAYS-1:0]     probe_way_sel,
    input  logic                    rsp_valid,
    input  logic                    rsp_dirty,
    input  logic [TAG_BITS-1:0]     rsp_tag,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [TAG_BITS+LSB-1:0] wb_addr,
    output logic [NUM_WAYS-1:0]     wb_way_sel,
    output logic                    done_valid,
    input  logic                    done_ready,
    output logic [WCW-1:0]          wb_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_ADV   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [LSB-1:0]      c_LAST_LINE = LSB'(LINES_PER_BANK - 1);
    localparam logic [NUM_WAYS-1:0] c_WAY0      = NUM_WAYS'(1);

    state_t                r_state;
    logic [LSB-1:0]        r_line;
    logic [NUM_WAYS-1:0]   r_way;
    logic [TAG_BITS-1:0]   r_tag;
    logic                  r_inval;
    logic [WCW-1:0]        r_wb_count;
    logic                  r_req_ready;
    logic                  r_busy;
    logic                  r_probe_valid;
    logic                  r_wb_valid;
    logic                  r_done_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_line        <= '0;
            r_way         <= c_WAY0;
            r_tag         <= '0;
            r_inval       <= 1'b0;
            r_wb_count    <= '0;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_probe_valid <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_done_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_state       <= S_ISSUE;
                        r_inval       <= req_inval_only;
                        r_line        <= '0;
                        r_way         <= c_WAY0;
                        r_wb_count    <= '0;
                        r_req_ready   <= 1'b0;
                        r_busy        <= 1'b1;
                        r_probe_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (probe_ready) begin
                        r_state       <= S_WAIT;
                        r_probe_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        if (rsp_dirty && !r_inval) begin
                            r_tag      <= rsp_tag;
                            r_wb_valid <= 1'b1;
                            r_state    <= S_WB;
                        end else begin
                            r_state    <= S_ADV;
                        end
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_wb_count <= r_wb_count + WCW'(1);
                        r_state    <= S_ADV;
                    end
                end
                S_ADV: begin
                    // Ways form the inner loop; a wrap out of the top way steps the line.
                    if (r_way[NUM_WAYS-1]) begin
                        r_way  <= c_WAY0;
                        r_line <= r_line + LSB'(1);
                    end else begin
                        r_way  <= r_way << 1;
                    end
                    if (r_way[NUM_WAYS-1] && (r_line == c_LAST_LINE)) begin
                        r_state      <= S_DONE;
                        r_done_valid <= 1'b1;
                    end else begin
                        r_state       <= S_ISSUE;
                        r_probe_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (done_ready) begin
                        r_done_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_req_ready   <= 1'b1;
                    r_busy        <= 1'b0;
                    r_probe_valid <= 1'b0;
                    r_wb_valid    <= 1'b0;
                    r_done_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign busy          = r_busy;
    assign probe_valid   = r_probe_valid;
    assign probe_line    = r_line;
    assign probe_way_sel = r_probe_valid ? r_way : '0;
    assign wb_valid      = r_wb_valid;
    assign wb_addr       = {r_tag, r_line};
    assign wb_way_sel    = r_way;
    assign done_valid    = r_done_valid;
    assign wb_count      = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_cache_flush_walker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_flush_walker
// Purpose  : Directed bench for cache_flush_walker (1-way and 4-way instances).
// Revision : 1.0
// ============================================================================
module tb_cache_flush_walker;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req1 = 1'b0, req4 = 1'b0, inval = 1'b0;
    logic probe_ready = 1'b1, wb_ready = 1'b1, done_ready = 1'b1;

    // 1-way instance: 64 lines
    logic        d1_req_ready, d1_busy, d1_probe_valid, d1_wb_valid, d1_done_valid;
    logic [5:0]  d1_probe_line;
    logic [0:0]  d1_probe_way, d1_wb_way;
    logic        d1_rsp_valid = 1'b0, d1_rsp_dirty = 1'b0;
    logic [19:0] d1_rsp_tag = '0;
    logic [25:0] d1_wb_addr;
    logic [6:0]  d1_wb_count;

    // 4-way instance: 64 lines x 4 ways
    logic        d4_req_ready, d4_busy, d4_probe_valid, d4_wb_valid, d4_done_valid;
    logic [5:0]  d4_probe_line;
    logic [3:0]  d4_probe_way, d4_wb_way;
    logic        d4_rsp_valid = 1'b0, d4_rsp_dirty = 1'b0;
    logic [19:0] d4_rsp_tag = '0;
    logic [25:0] d4_wb_addr;
    logic [8:0]  d4_wb_count;

    cache_flush_walker u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req1), .req_inval_only(inval), .req_ready(d1_req_ready), .busy(d1_busy),
        .probe_valid(d1_probe_valid), .probe_ready(probe_ready),
        .probe_line(d1_probe_line), .probe_way_sel(d1_probe_way),
        .rsp_valid(d1_rsp_valid), .rsp_dirty(d1_rsp_dirty), .rsp_tag(d1_rsp_tag),
        .wb_valid(d1_wb_valid), .wb_ready(wb_ready), .wb_addr(d1_wb_addr), .wb_way_sel(d1_wb_way),
        .done_valid(d1_done_valid), .done_ready(done_ready), .wb_count(d1_wb_count)
    );

    cache_flush_walker #(.CACHE_SIZE(4096), .NUM_WAYS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req4), .req_inval_only(inval), .req_ready(d4_req_ready), .busy(d4_busy),
        .probe_valid(d4_probe_valid), .probe_ready(probe_ready),
        .probe_line(d4_probe_line), .probe_way_sel(d4_probe_way),
        .rsp_valid(d4_rsp_valid), .rsp_dirty(d4_rsp_dirty), .rsp_tag(d4_rsp_tag),
        .wb_valid(d4_wb_valid), .wb_ready(wb_ready), .wb_addr(d4_wb_addr), .wb_way_sel(d4_wb_way),
        .done_valid(d4_done_valid), .done_ready(done_ready), .wb_count(d4_wb_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Tag-stage contents seen by each instance
    logic        dirty1 [64];
    logic [19:0] tag1   [64];
    logic        dirty4 [64][4];
    logic [19:0] tag4   [64][4];

    // Monitor state for the 1-way instance
    int          p1_cnt, p1_err, p1_exp, p1_stall_err, wb1_cnt, wb1_high, wb1_stall_err;
    logic        p1_pend = 1'b0, p1_hold = 1'b0, wb1_hold = 1'b0;
    logic [5:0]  p1_pl, p1_hl;
    logic [25:0] wb1_last, wb1_ha;

    // Monitor state for the 4-way instance
    int          p4_cnt, p4_err, p4_exp, wb4_cnt;
    logic        p4_pend = 1'b0;
    logic [5:0]  p4_pl;
    int          p4_pw;
    logic [25:0] wb4_addr [4];
    logic [3:0]  wb4_way  [4];

    // Inputs change at posedge+1; handshakes are observed at the negedge before they complete.
    always @(negedge clk) begin
        if (reset_n) begin
            if (p1_hold && !(d1_probe_valid && d1_probe_line == p1_hl && d1_probe_way == 1'b1))
                p1_stall_err++;
            if (wb1_hold && !(d1_wb_valid && d1_wb_addr == wb1_ha && d1_wb_way == 1'b1))
                wb1_stall_err++;
            p1_hold  = d1_probe_valid && !probe_ready;
            p1_hl    = d1_probe_line;
            wb1_hold = d1_wb_valid && !wb_ready;
            wb1_ha   = d1_wb_addr;
            if (d1_wb_valid) wb1_high++;
            if (d1_probe_valid && probe_ready) begin
                if (d1_probe_line !== 6'(p1_exp) || d1_probe_way !== 1'b1) p1_err++;
                p1_exp++;
                p1_cnt++;
                p1_pend = 1'b1;
                p1_pl   = d1_probe_line;
            end
            if (d1_wb_valid && wb_ready) begin
                wb1_cnt++;
                wb1_last = d1_wb_addr;
            end
            if (d4_probe_valid && probe_ready) begin
                if (d4_probe_line !== 6'(p4_exp / 4) || d4_probe_way !== 4'(1 << (p4_exp % 4)))
                    p4_err++;
                p4_exp++;
                p4_cnt++;
                p4_pend = 1'b1;
                p4_pl   = d4_probe_line;
                p4_pw   = 0;
                for (int k = 0; k < 4; k++) if (d4_probe_way[k]) p4_pw = k;
            end
            if (d4_wb_valid && wb_ready) begin
                if (wb4_cnt < 4) begin
                    wb4_addr[wb4_cnt] = d4_wb_addr;
                    wb4_way[wb4_cnt]  = d4_wb_way;
                end
                wb4_cnt++;
            end
        end else begin
            p1_hold  = 1'b0;
            wb1_hold = 1'b0;
        end
    end

    // Tag stage answers one cycle after each accepted probe.
    always @(posedge clk) begin
        #1;
        d1_rsp_valid = p1_pend;
        d1_rsp_dirty = p1_pend && dirty1[p1_pl];
        d1_rsp_tag   = tag1[p1_pl];
        p1_pend      = 1'b0;
        d4_rsp_valid = p4_pend;
        d4_rsp_dirty = p4_pend && dirty4[p4_pl][p4_pw];
        d4_rsp_tag   = tag4[p4_pl][p4_pw];
        p4_pend      = 1'b0;
    end

    task automatic clear_mon();
        p1_cnt = 0; p1_err = 0; p1_exp = 0; p1_stall_err = 0;
        wb1_cnt = 0; wb1_high = 0; wb1_stall_err = 0; wb1_last = '0;
        p4_cnt = 0; p4_err = 0; p4_exp = 0; wb4_cnt = 0;
        for (int i = 0; i < 4; i++) begin wb4_addr[i] = '0; wb4_way[i] = '0; end
    endtask

    task automatic set_tables(input logic all_dirty);
        for (int l = 0; l < 64; l++) begin
            dirty1[l] = all_dirty;
            tag1[l]   = 20'(l * 4099 + 7);
            for (int w = 0; w < 4; w++) begin
                dirty4[l][w] = 1'b0;
                tag4[l][w]   = 20'(l * 16 + w);
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Returns at posedge+1 right after the request is accepted.
    task automatic start1(input logic inv);
        @(posedge clk); #1;
        req1 = 1'b1; inval = inv;
        @(posedge clk); #1;
        req1 = 1'b0;
    endtask

    task automatic wait_done1(input int budget, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        while (cycles < budget && !ok) begin
            @(negedge clk);
            cycles++;
            if (d1_done_valid) ok = 1'b1;
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        clear_mon();
        set_tables(1'b0);
        do_reset();
        n_total++; if (d1_req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", d1_req_ready); else n_pass++;
        n_total++; if (d1_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", d1_busy); else n_pass++;
        n_total++; if (d1_probe_valid !== 1'b0 || d1_probe_way !== 1'b0)
            $display("FAIL reset_probe: got valid=%b way=%b expected 0/0", d1_probe_valid, d1_probe_way); else n_pass++;
        n_total++; if (d1_wb_valid !== 1'b0 || d1_done_valid !== 1'b0)
            $display("FAIL reset_wb_done: got %b/%b expected 0/0", d1_wb_valid, d1_done_valid); else n_pass++;
        n_total++; if (d1_wb_count !== 7'd0) $display("FAIL reset_wb_count: got %0d expected 0", d1_wb_count); else n_pass++;
        n_total++; if (d4_req_ready !== 1'b1 || d4_busy !== 1'b0)
            $display("FAIL reset_d4: got ready=%b busy=%b expected 1/0", d4_req_ready, d4_busy); else n_pass++;
    endtask

    task automatic test_clean_walk();
        int cyc; bit ok;
        clear_mon();
        set_tables(1'b0);
        start1(1'b0);
        n_total++; if (d1_busy !== 1'b1 || d1_req_ready !== 1'b0)
            $display("FAIL walk_busy: got busy=%b ready=%b expected 1/0", d1_busy, d1_req_ready); else n_pass++;
        wait_done1(400, cyc, ok);
        check_int("walk_done_seen", int'(ok), 1);
        check_int("walk_done_cycle", cyc, 193);
        check_int("walk_probes", p1_cnt, 64);
        check_int("walk_order_err", p1_err, 0);
        check_int("walk_wb_high", wb1_high, 0);
        check_int("walk_wb_count", int'(d1_wb_count), 0);
        @(posedge clk); #1;
        n_total++; if (d1_req_ready !== 1'b1 || d1_busy !== 1'b0)
            $display("FAIL walk_idle: got ready=%b busy=%b expected 1/0", d1_req_ready, d1_busy); else n_pass++;
    endtask

    task automatic test_four_way();
        int cyc; bit ok;
        clear_mon();
        set_tables(1'b0);
        dirty4[3][2]  = 1'b1; tag4[3][2]  = 20'h00ABC;
        dirty4[63][3] = 1'b1; tag4[63][3] = 20'hFFFFF;
        @(posedge clk); #1; req4 = 1'b1; inval = 1'b0;
        @(posedge clk); #1; req4 = 1'b0;
        ok = 1'b0; cyc = 0;
        while (cyc < 2000 && !ok) begin
            @(negedge clk); cyc++;
            if (d4_done_valid) ok = 1'b1;
        end
        check_int("w4_done_seen", int'(ok), 1);
        check_int("w4_probes", p4_cnt, 256);
        check_int("w4_order_err", p4_err, 0);
        check_int("w4_wb_cnt", wb4_cnt, 2);
        n_total++; if (wb4_addr[0] !== {20'h00ABC, 6'd3} || wb4_way[0] !== 4'b0100)
            $display("FAIL w4_wb0: got addr=%h way=%b expected %h/0100", wb4_addr[0], wb4_way[0], {20'h00ABC, 6'd3}); else n_pass++;
        n_total++; if (wb4_addr[1] !== {20'hFFFFF, 6'd63} || wb4_way[1] !== 4'b1000)
            $display("FAIL w4_wb1: got addr=%h way=%b expected %h/1000", wb4_addr[1], wb4_way[1], {20'hFFFFF, 6'd63}); else n_pass++;
        check_int("w4_wb_count", int'(d4_wb_count), 2);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int cyc; bit ok; bit seen;
        clear_mon();
        set_tables(1'b0);
        dirty1[10] = 1'b1;
        start1(1'b0);
        seen = 1'b0; cyc = 0;
        while (cyc < 200 && !seen) begin
            if (d1_probe_valid && d1_probe_line == 6'd10) seen = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        check_int("bp_line10_seen", int'(seen), 1);
        probe_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        probe_ready = 1'b1;
        seen = 1'b0; cyc = 0;
        while (cyc < 20 && !seen) begin
            if (d1_wb_valid) seen = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        check_int("bp_wb_seen", int'(seen), 1);
        wb_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        wb_ready = 1'b1;
        wait_done1(400, cyc, ok);
        check_int("bp_done_seen", int'(ok), 1);
        check_int("bp_probes", p1_cnt, 64);
        check_int("bp_order_err", p1_err, 0);
        check_int("bp_probe_stable_err", p1_stall_err, 0);
        check_int("bp_wb_stable_err", wb1_stall_err, 0);
        check_int("bp_wb_cnt", wb1_cnt, 1);
        n_total++; if (wb1_last !== {20'(10 * 4099 + 7), 6'd10})
            $display("FAIL bp_wb_addr: got %h expected %h", wb1_last, {20'(10 * 4099 + 7), 6'd10}); else n_pass++;
        check_int("bp_wb_count", int'(d1_wb_count), 1);
        @(posedge clk); #1;
    endtask

    task automatic test_inval_only();
        int cyc; bit ok;
        clear_mon();
        set_tables(1'b1);
        start1(1'b1);
        wait_done1(400, cyc, ok);
        check_int("inv_done_seen", int'(ok), 1);
        check_int("inv_probes", p1_cnt, 64);
        check_int("inv_wb_high", wb1_high, 0);
        check_int("inv_wb_count", int'(d1_wb_count), 0);
        @(posedge clk); #1;
        inval = 1'b0;
    endtask

    task automatic test_mid_reset();
        int cyc; bit ok; bit seen;
        clear_mon();
        set_tables(1'b0);
        dirty1[20] = 1'b1;
        wb_ready = 1'b0;
        start1(1'b0);
        seen = 1'b0; cyc = 0;
        while (cyc < 200 && !seen) begin
            if (d1_wb_valid) seen = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        check_int("mr_wb_seen", int'(seen), 1);
        check_int("mr_wb_line", int'(d1_wb_addr[5:0]), 20);
        do_reset();
        n_total++; if (d1_req_ready !== 1'b1 || d1_busy !== 1'b0 || d1_wb_valid !== 1'b0 || d1_probe_valid !== 1'b0)
            $display("FAIL mr_idle: got ready=%b busy=%b wb=%b probe=%b expected 1/0/0/0",
                     d1_req_ready, d1_busy, d1_wb_valid, d1_probe_valid); else n_pass++;
        wb_ready = 1'b1;
        dirty1[20] = 1'b0;
        clear_mon();
        start1(1'b0);
        n_total++; if (d1_probe_valid !== 1'b1 || d1_probe_line !== 6'd0)
            $display("FAIL mr_restart: got valid=%b line=%0d expected 1/0", d1_probe_valid, d1_probe_line); else n_pass++;
        wait_done1(400, cyc, ok);
        check_int("mr_done_seen", int'(ok), 1);
        check_int("mr_probes", p1_cnt, 64);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc; bit ok; int ready_err; int held;
        clear_mon();
        set_tables(1'b0);
        ready_err = 0;
        done_ready = 1'b0;
        @(posedge clk); #1; req1 = 1'b1;
        @(posedge clk); #1;
        ok = 1'b0; cyc = 0;
        while (cyc < 400 && !ok) begin
            @(negedge clk); cyc++;
            if (d1_req_ready !== 1'b0) ready_err++;
            if (d1_done_valid) ok = 1'b1;
        end
        check_int("b2b_done_seen", int'(ok), 1);
        check_int("b2b_ready_low", ready_err, 0);
        check_int("b2b_probes", p1_cnt, 64);
        held = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (d1_done_valid === 1'b1 && d1_probe_valid === 1'b0 && d1_req_ready === 1'b0) held++;
        end
        check_int("b2b_done_held", held, 4);
        @(posedge clk); #1; done_ready = 1'b1;
        @(posedge clk); #1;
        n_total++; if (d1_req_ready !== 1'b1 || d1_busy !== 1'b0)
            $display("FAIL b2b_idle: got ready=%b busy=%b expected 1/0", d1_req_ready, d1_busy); else n_pass++;
        @(posedge clk); #1;
        req1 = 1'b0;
        n_total++; if (d1_busy !== 1'b1 || d1_probe_valid !== 1'b1 || d1_probe_line !== 6'd0)
            $display("FAIL b2b_restart: got busy=%b probe=%b line=%0d expected 1/1/0",
                     d1_busy, d1_probe_valid, d1_probe_line); else n_pass++;
        wait_done1(400, cyc, ok);
        check_int("b2b_second_done", int'(ok), 1);
        check_int("b2b_total_probes", p1_cnt, 128);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_clean_walk();
        test_four_way();
        test_backpressure();
        test_inval_only();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
